// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner with scan-level debounce and a 4-digit entry register.
// Optional build macro KEYPAD_CLEAR_KEY_EN: key C clears the digits instead of being shifted in.
module keypad_entry #(
  parameter int SCAN_DIV  = 25000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_FULL   = CW'(DEB_SCANS);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    scan_code_q, scan_code_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d, dig4_q, dig4_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;

  logic [3:0]    low;
  logic [2:0]    nlows;
  logic [1:0]    low_idx;
  logic [2:0]    hits_sum;
  logic [1:0]    hits_new;
  logic [3:0]    code_new;
  logic          sample;
  logic          scan_end;
  logic          accept;
  logic [3:0]    acc_code;
  logic [CW-1:0] cnt_inc;

  function automatic logic [3:0] key_at(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({c, r})
      4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'h0;
      4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'hF;
      4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
      4'hC: k = 4'hA;  4'hD: k = 4'hB;  4'hE: k = 4'hC;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Column scan: accumulate low rows over the four column samples; hits saturates at 2 (MULTI).
  always_comb begin
    low     = ~row_s2_q;
    nlows   = {2'b0, low[0]} + {2'b0, low[1]} + {2'b0, low[2]} + {2'b0, low[3]};
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) low_idx = 2'(i);
    end
    hits_sum    = {1'b0, hits_q} + nlows;
    hits_new    = (hits_sum > 3'd1) ? 2'd2 : hits_sum[1:0];
    code_new    = (hits_q == 2'd0 && nlows == 3'd1) ? key_at(col_idx_q, low_idx) : scan_code_q;
    sample      = (dwell_q == DWELL_LAST);
    scan_end    = sample && (col_idx_q == 2'd3);
    dwell_d     = sample ? '0 : dwell_q + DW'(1);
    col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;
    hits_d      = hits_q;
    scan_code_d = scan_code_q;
    if (sample) begin
      hits_d      = scan_end ? 2'd0 : hits_new;
      scan_code_d = code_new;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    acc_code = cand_q;
    cnt_inc  = cnt_q + CW'(1);
    if (scan_end) begin
      case (state_q)
        ST_IDLE: begin
          if (hits_new == 2'd1) begin
            cand_d = code_new;
            if (DEB_SCANS == 1) begin
              accept   = 1'b1;
              acc_code = code_new;
              state_d  = ST_HELD;
              cnt_d    = '0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (hits_new == 2'd1 && code_new == cand_q) begin
            if (cnt_inc == DEB_FULL) begin
              accept  = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (hits_new == 2'd0) begin
            if (cnt_inc == DEB_FULL) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? acc_code : key_code_q;
    dig1_d = dig1_q;
    dig2_d = dig2_q;
    dig3_d = dig3_q;
    dig4_d = dig4_q;
`ifdef KEYPAD_CLEAR_KEY_EN
    if (accept && acc_code == 4'hC) begin
      dig1_d = 4'h0;
      dig2_d = 4'h0;
      dig3_d = 4'h0;
      dig4_d = 4'h0;
    end else if (accept) begin
      dig1_d = dig2_q;
      dig2_d = dig3_q;
      dig3_d = dig4_q;
      dig4_d = acc_code;
    end
`else
    if (accept) begin
      dig1_d = dig2_q;
      dig2_d = dig3_q;
      dig3_d = dig4_q;
      dig4_d = acc_code;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      hits_q      <= 2'd0;
      scan_code_q <= 4'h0;
      state_q     <= ST_IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      dig1_q      <= 4'h0;
      dig2_q      <= 4'h0;
      dig3_q      <= 4'h0;
      dig4_q      <= 4'h0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      hits_q      <= hits_d;
      scan_code_q <= scan_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      dig1_q      <= dig1_d;
      dig2_q      <= dig2_d;
      dig3_q      <= dig3_d;
      dig4_q      <= dig4_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign dig1      = dig1_q;
  assign dig2      = dig2_q;
  assign dig3      = dig3_q;
  assign dig4      = dig4_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad scanner bench; pressed keys are a 16-bit mask indexed by key code,
// and the reference tracks scan results as streaks of identical presses and quiet scans.
module tb_keypad_entry;
  localparam int SD   = 4;
  localparam int DEB  = 2;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] row;
  logic [3:0] col, dig1, dig2, dig3, dig4, key_code;
  logic       key_valid;

  always #5 clk = ~clk;

  keypad_entry #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
    .clk(clk), .clr(clr), .row(row), .col(col),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .key_valid(key_valid), .key_code(key_code)
  );

  // Physical keypad: position (column c, row r) -> key code.
  logic [3:0] keymap [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                              4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};

  int          k = 0;          // clock edges since the last edge that saw clr
  logic        clr_seen = 1'b1;
  logic [15:0] cur_mask = '0;
  logic [15:0] ended_mask = '0;
  logic [3:0]  noise = 4'hF;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int last_pulse_k = -1;

  // Reference state
  bit         m_locked;
  int         m_streak, m_quiet;
  logic [3:0] m_key;
  logic       exp_valid;
  logic [3:0] exp_code;
  logic [3:0] m_dig[$];

  always @(posedge clk) begin
    clr_seen <= clr;
    if (clr) k <= 0;
    else begin
      k <= k + 1;
      if ((k + 1) % SCAN == 0) ended_mask <= cur_mask;
    end
  end

  // Rows only matter in the cycle captured by the synchronizer for the upcoming sample; elsewhere they are junk.
  always_comb begin
    row = noise;
    if (k % SD == 1) begin
      for (int r = 0; r < 4; r++) row[r] = ~cur_mask[keymap[((k / SD) % 4) * 4 + r]];
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (k=%0d t=%0t)", name, act, exp, k, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_streak = 0; m_quiet = 0; m_key = 4'h0;
    exp_valid = 1'b0; exp_code = 4'h0;
    m_dig = '{4'h0, 4'h0, 4'h0, 4'h0};
  endtask

  task automatic model_accept(input logic [3:0] key);
    exp_valid = 1'b1;
    exp_code  = key;
`ifdef KEYPAD_CLEAR_KEY_EN
    if (key == 4'hC) begin
      m_dig = '{4'h0, 4'h0, 4'h0, 4'h0};
      return;
    end
`endif
    m_dig.push_back(key);
    void'(m_dig.pop_front());
  endtask

  task automatic model_scan(input logic [15:0] mask);
    int n;
    logic [3:0] key;
    n = $countones(mask);
    key = 4'h0;
    for (int i = 0; i < 16; i++) if (mask[i]) key = 4'(i);
    if (!m_locked) begin
      if (n == 1 && (m_streak == 0 || key == m_key)) begin
        if (m_streak == 0) m_key = key;
        m_streak++;
      end else m_streak = 0;
      if (m_streak == DEB) begin
        model_accept(m_key);
        m_locked = 1; m_streak = 0; m_quiet = 0;
      end
    end else begin
      if (n == 0) m_quiet++; else m_quiet = 0;
      if (m_quiet == DEB) begin
        m_locked = 0; m_quiet = 0;
      end
    end
  endtask

  // Compare process: every cycle, against the reference.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      noise = 4'($urandom);
      if (clr_seen) model_reset();
      else begin
        exp_valid = 1'b0;
        if (k > 0 && k % SCAN == 0) model_scan(ended_mask);
      end
      if (key_valid === 1'b1) begin
        pulses++;
        last_pulse_k = k;
      end
      chk("col", col, ~(4'b0001 << ((k / SD) % 4)));
      chk("key_valid", {3'b0, key_valid}, {3'b0, exp_valid});
      chk("key_code", key_code, exp_code);
      chk("dig1", dig1, m_dig[0]);
      chk("dig2", dig2, m_dig[1]);
      chk("dig3", dig3, m_dig[2]);
      chk("dig4", dig4, m_dig[3]);
    end
  end

  task automatic do_clr(input int n);
    @(negedge clk);
    clr = 1'b1;
    repeat (n) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_scan_end();
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (k % SCAN != 0 && guard < 3 * SCAN);
    if (k % SCAN != 0) begin
      total++; bad++;
      $display("FAIL scan_end_timeout: k=%0d", k);
    end
  endtask

  task automatic scans(input logic [15:0] mask, input int n);
    cur_mask = mask;
    repeat (n) wait_scan_end();
  endtask

  int p0;
  int keys5[5] = '{1, 2, 3, 4, 9};
  int entry[4] = '{1, 2, 3, 12};

  initial begin
    // Idle scanning
    do_clr(3);
    scans(16'h0, 4);
    chk_int("idle_pulses", pulses, 0);

    // Single key 5, then release and press again
    do_clr(2);
    p0 = pulses;
    scans(16'h1 << 5, 3);
    scans(16'h0, 2);
    @(negedge clk);
    chk_int("k5_pulses", pulses - p0, 1);
    chk("k5_code", key_code, 4'h5);
    chk("k5_dig4", dig4, 4'h5);
    chk("k5_dig1", dig1, 4'h0);
    scans(16'h1 << 5, 2);
    scans(16'h0, 2);
    chk_int("k5_repress", pulses - p0, 2);

    // Sequence 1,2,3,4,9
    do_clr(2);
    p0 = pulses;
    foreach (keys5[i]) begin
      scans(16'h1 << keys5[i], 3);
      scans(16'h0, 3);
    end
    @(negedge clk);
    chk_int("seq_pulses", pulses - p0, 5);
    chk("seq_dig1", dig1, 4'h2);
    chk("seq_dig2", dig2, 4'h3);
    chk("seq_dig3", dig3, 4'h4);
    chk("seq_dig4", dig4, 4'h9);

    // Short press and double press are rejected
    do_clr(2);
    p0 = pulses;
    scans(16'h1 << 7, 1);
    scans(16'h0, 3);
    scans((16'h1 << 1) | (16'h1 << 2), 4);
    scans(16'h0, 2);
    chk_int("reject_pulses", pulses - p0, 0);

    // Clear key
    do_clr(2);
    foreach (entry[i]) begin
      scans(16'h1 << entry[i], 2);
      scans(16'h0, 2);
    end
    @(negedge clk);
    chk("clr_key_code", key_code, 4'hC);
`ifdef KEYPAD_CLEAR_KEY_EN
    chk("clr_dig1", dig1, 4'h0);
    chk("clr_dig4", dig4, 4'h0);
`else
    chk("clr_dig1", dig1, 4'h1);
    chk("clr_dig2", dig2, 4'h2);
    chk("clr_dig3", dig3, 4'h3);
    chk("clr_dig4", dig4, 4'hC);
`endif

    // Reset in the middle of debounce with key 8 held
    scans(16'h1 << 8, 1);
    repeat (5) @(negedge clk);
    do_clr(1);
    p0 = pulses;
    scans(16'h1 << 8, 2);
    @(negedge clk);
    chk_int("mid_clr_pulses", pulses - p0, 1);
    chk_int("mid_clr_pulse_k", last_pulse_k, 2 * SCAN);
    chk("mid_clr_code", key_code, 4'h8);
    scans(16'h0, 2);

    // Randomized presses, multi-presses, gaps and occasional resets
    for (int it = 0; it < 60; it++) begin
      int kind;
      logic [15:0] m;
      kind = int'($urandom_range(0, 9));
      m = '0;
      if (kind >= 3) m[$urandom_range(0, 15)] = 1'b1;
      if (kind >= 8) m[$urandom_range(0, 15)] = 1'b1;
      scans(m, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 14) == 0) begin
        repeat (int'($urandom_range(1, SCAN - 2))) @(negedge clk);
        do_clr(int'($urandom_range(1, 3)));
      end
    end
    scans(16'h0, 3);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, 25000, clk cycles each column is driven (min 4).
REQ-002 Parameter DEB_SCANS, 4, consecutive full scans needed to accept a press or a release (min 1).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 row  input  4  keypad rows, active-low, asynchronous to clk.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 dig1..dig4  output  4 each  entered digits, dig1 leftmost, dig4 rightmost, same order as the display digit inputs.
REQ-008 key_valid  output  1  one-cycle pulse on each accepted key.
REQ-009 key_code  output  4  code of the last accepted key, held between pulses.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Column index c SHALL rotate 0,1,2,3,0; col = ~(1<<c); c advances when a dwell counter reaches SCAN_DIV-1, then the counter returns to 0.
REQ-012 Synchronized rows SHALL be sampled only in the last dwell cycle of each column.
REQ-013 Key map (col,row): c0: 1,4,7,0; c1: 2,5,8,F; c2: 3,6,9,E; c3: A,B,C,D (row 0..3).
REQ-014 A full scan ends with the column-3 sample; its result SHALL be NONE (no low row seen), SINGLE(code) (exactly one low row across all four columns), or MULTI (more than one).
REQ-015 FSM states IDLE, DEBOUNCE, HELD, evaluated only at full-scan end.
REQ-016 IDLE: SINGLE(k) -> DEBOUNCE, candidate=k, count=1; NONE/MULTI -> stay.
REQ-017 DEBOUNCE: SINGLE(candidate) -> count+1; when count reaches DEB_SCANS -> accept, go HELD, count=0; any other result -> IDLE.
REQ-018 HELD: NONE -> count+1, IDLE when count reaches DEB_SCANS; SINGLE/MULTI -> count=0, stay (no repeat, no new key while held).
REQ-019 With DEB_SCANS=1 acceptance SHALL occur at the end of the first SINGLE scan, skipping DEBOUNCE.
REQ-020 Accept SHALL, in the same cycle: key_valid=1 for one cycle, key_code=candidate, dig1<=dig2, dig2<=dig3, dig3<=dig4, dig4<=candidate (dig1 value discarded).
REQ-021 Latency: key_valid SHALL assert 1 cycle after the full-scan-end sample that completes the debounce.
REQ-022 Row changes between sampling points SHALL have no effect.

Reset
REQ-023 clr SHALL take priority over all other activity, including mid-dwell and mid-debounce.
REQ-024 After clr: col=4'b1110, dwell counter 0, state IDLE, count 0, dig1..dig4=0, key_valid=0, key_code=0, synchronizer flops 1.
REQ-025 A key held across clr release SHALL be debounced afresh from IDLE.

Configuration
REQ-026 Macro KEYPAD_CLEAR_KEY_EN: defined -> accepting code C SHALL set dig1..dig4 to 0 instead of shifting, still pulse key_valid, key_code=C.
REQ-027 Not defined -> code C SHALL be entered as an ordinary digit per REQ-020.

Verification (SCAN_DIV=4, DEB_SCANS=2)
REQ-028 clr then idle rows=4'hF -> col cycles 1110,1101,1011,0111 every 4 clks; key_valid never asserts; digits stay 0.
REQ-029 Hold key 5 (row1 low only while col=1101) for 3 scans then release -> one key_valid, key_code=5, dig4=5, dig1..dig3=0; release of 2 scans returns to IDLE.
REQ-030 Press 1,2,3,4,9 in turn, each held 3 scans, released 3 scans -> final dig1..dig4 = 2,3,4,9, five key_valid pulses.
REQ-031 Key 7 present for 1 scan only, or keys 1 and 2 together for 4 scans -> no key_valid.
REQ-032 Digits 1,2,3 entered then key C -> with KEYPAD_CLEAR_KEY_EN all digits 0, key_code=C; without it dig1..dig4 = 1,2,3,C.
REQ-033 Assert clr during DEBOUNCE with key 8 held -> outputs per REQ-024 next cycle; continued hold yields key_valid after 2 full scans post-reset.
